// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
//
// Purpose:
//   Shares one W-bit signed ripple adder between two independent requesters.
//   A grant is issued only in IDLE. Round-robin or fixed-priority selection
//   is chosen by a parameter. The granted operands are registered, then
//   summed in CALC. The tagged result is held in HOLD until the consumer
//   accepts it. This block is the only driver of the adder's inputs.
//
// Parameters:
//   W     - operand width in bits; the result is W+1 bits wide
//   FAIR  - 1: round-robin between ports, 0: port 0 always wins
//   CNTW  - width of the completed-operation counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req0/1     port request, held with its operands until granted
//   a0/1, b0/1 two's complement operands
//   cin0/1     carry-in
//   gnt0/1     combinational grant; operands are captured on that edge
//   res_valid  result valid (held until res_ready)
//   res_ready  consumer accepts the result
//   res_sum    sign-extended (W+1)-bit sum
//   res_cout   carry out of bit W of the sign-extended addition
//   res_ovf    result does not fit in W signed bits
//   res_id     port that issued the operation
//   busy       state is not IDLE
//   op_count   accepted operations, wraps modulo 2^CNTW
// ---------------------------------------------------------------------------
module adder_share_arb #(
    parameter int W    = 5,
    parameter int FAIR = 1,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic [W-1:0]    a0,
    input  logic [W-1:0]    b0,
    input  logic            cin0,
    output logic            gnt0,
    input  logic            req1,
    input  logic [W-1:0]    a1,
    input  logic [W-1:0]    b1,
    input  logic            cin1,
    output logic            gnt1,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W:0]      res_sum,
    output logic            res_cout,
    output logic            res_ovf,
    output logic            res_id,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    logic           last_grant;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           cin_q;
    logic           id_q;

    logic           pick1;
    logic [W:0]     ext_a;
    logic [W:0]     ext_b;
    logic [W:0]     sum_w;
    logic [W+1:0]   carry;

    // Arbitration decision: does port 1 win if we are in IDLE?
    // On a tie, round-robin hands the grant to the port that did not win
    // last time; fixed priority always hands it to port 0.
    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1) begin
            if (FAIR != 0) begin
                pick1 = (last_grant == 1'b0);
            end else begin
                pick1 = 1'b0;
            end
        end else begin
            pick1 = req1;
        end
    end

    // Grants exist only in IDLE, so a request that arrives while an
    // operation is in flight simply waits with req held high.
    assign gnt0 = (state == IDLE) && req0 && !pick1;
    assign gnt1 = (state == IDLE) && req1 && pick1;
    assign busy = (state != IDLE);

    // Shared ripple adder over the sign-extended (W+1)-bit operands.
    // Bits [W:0] of this chain equal the low bits of the W+2 bit signed sum,
    // and the carry out of the top stage is the unsigned carry-out.
    always_comb begin
        ext_a    = {a_q[W-1], a_q};
        ext_b    = {b_q[W-1], b_q};
        sum_w    = '0;
        carry    = '0;
        carry[0] = cin_q;
        for (int i = 0; i <= W; i++) begin
            sum_w[i]   = ext_a[i] ^ ext_b[i] ^ carry[i];
            carry[i+1] = (ext_a[i] & ext_b[i]) | (carry[i] & (ext_a[i] ^ ext_b[i]));
        end
    end

    // Control FSM with registered result outputs. Reset drops any operation
    // in flight and makes port 0 the first round-robin winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_ovf    <= 1'b0;
            res_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0) begin
                        a_q        <= a0;
                        b_q        <= b0;
                        cin_q      <= cin0;
                        id_q       <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= CALC;
                    end else if (gnt1) begin
                        a_q        <= a1;
                        b_q        <= b1;
                        cin_q      <= cin1;
                        id_q       <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    res_sum   <= sum_w;
                    res_cout  <= carry[W+1];
                    // A (W+1)-bit result fits in W bits only when its top two bits agree
                    res_ovf   <= sum_w[W] ^ sum_w[W-1];
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNTW'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arb
//
// Self-checking bench for adder_share_arb. A round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share every input. Expected results come
// from integer arithmetic on the operands. Expected grants come from a
// one-bit "who won last" model.
// ---------------------------------------------------------------------------
module tb_adder_share_arb;

    localparam int W    = 5;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0, req1, cin0, cin1, res_ready;
    logic [W-1:0]    a0, b0, a1, b1;

    logic            gnt0, gnt1, res_valid, res_cout, res_ovf, res_id, busy;
    logic [W:0]      res_sum;
    logic [CNTW-1:0] op_count;

    logic            fp_gnt0, fp_gnt1, fp_res_valid, fp_res_cout, fp_res_ovf, fp_res_id, fp_busy;
    logic [W:0]      fp_res_sum;
    logic [CNTW-1:0] fp_op_count;

    int vectors     = 0;
    int miscompares = 0;
    bit model_last;
    int exp_count;

    always #5 clk = ~clk;

    adder_share_arb #(.W(W), .FAIR(1), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1), .gnt1(gnt1),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id),
        .busy(busy), .op_count(op_count)
    );

    adder_share_arb #(.W(W), .FAIR(0), .CNTW(CNTW)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0), .gnt0(fp_gnt0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1), .gnt1(fp_gnt1),
        .res_valid(fp_res_valid), .res_ready(res_ready), .res_sum(fp_res_sum),
        .res_cout(fp_res_cout), .res_ovf(fp_res_ovf), .res_id(fp_res_id),
        .busy(fp_busy), .op_count(fp_op_count)
    );

    // Reference arithmetic: returns {ovf, cout, sum[W:0]}
    function automatic logic [W+2:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int sa, sb, s, ua, ub, cout, ovf;
        logic [W:0] sum;
        sa   = $signed(a);
        sb   = $signed(b);
        s    = sa + sb + int'(c);
        sum  = s[W:0];
        ua   = sa & ((1 << (W + 1)) - 1);
        ub   = sb & ((1 << (W + 1)) - 1);
        cout = ((ua + ub + int'(c)) >> (W + 1)) & 1;
        ovf  = ((s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)))) ? 1 : 0;
        return {ovf[0], cout[0], sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick();
        rst_n      = 1'b1;
        model_last = 1'b1;
        exp_count  = 0;
    endtask

    // One operation on dut from a single port, with res_ready withheld for
    // 'hold' cycles while both ports request (no grant may appear).
    task automatic run_op(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input int hold, input string tag);
        logic [W+2:0] exp;
        exp       = model_add(a, b, c);
        res_ready = 1'b0;
        if (port == 1'b0) begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = c;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        end
        #1;
        vectors++;
        if ({gnt1, gnt0} !== (port ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("[TB] FAIL %s grant: got %b expected %b", tag, {gnt1, gnt0}, (port ? 2'b10 : 2'b01));
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;
        a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
        a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
        vectors++;
        if ({busy, res_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL %s calc busy/valid: got %b expected 10", tag, {busy, res_valid});
        end
        tick();
        vectors++;
        if ({res_valid, res_ovf, res_cout, res_sum} !== {1'b1, exp}) begin
            miscompares++;
            $display("[TB] FAIL %s result v/ovf/cout/sum: got %b expected %b", tag,
                     {res_valid, res_ovf, res_cout, res_sum}, {1'b1, exp});
        end
        vectors++;
        if (res_id !== port) begin
            miscompares++;
            $display("[TB] FAIL %s res_id: got %b expected %b", tag, res_id, port);
        end
        model_last = port;
        for (int i = 0; i < hold; i++) begin
            req0 = 1'b1; req1 = 1'b1;
            #1;
            vectors++;
            if ({gnt1, gnt0, busy} !== 3'b001) begin
                miscompares++;
                $display("[TB] FAIL %s hold gnt1/gnt0/busy: got %b expected 001", tag, {gnt1, gnt0, busy});
            end
            tick();
            vectors++;
            if ({res_valid, res_ovf, res_cout, res_sum} !== {1'b1, exp}) begin
                miscompares++;
                $display("[TB] FAIL %s hold stability: got %b expected %b", tag,
                         {res_valid, res_ovf, res_cout, res_sum}, {1'b1, exp});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CNTW);
        vectors++;
        if ({res_valid, busy} !== 2'b00 || op_count !== CNTW'(exp_count)) begin
            miscompares++;
            $display("[TB] FAIL %s accept valid/busy/count: got %b/%0d expected 00/%0d", tag,
                     {res_valid, busy}, op_count, exp_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({res_valid, res_cout, res_ovf, res_id, busy, gnt0, gnt1} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset flags: got %b expected 0000000",
                     {res_valid, res_cout, res_ovf, res_id, busy, gnt0, gnt1});
        end
        vectors++;
        if (res_sum !== '0 || op_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset sum/count: got %b/%0d expected 0/0", res_sum, op_count);
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 5'b01111, 5'b00001, 1'b0, 0, "pos_ovf");
        run_op(1'b1, 5'b10000, 5'b10000, 1'b0, 0, "neg_ovf");
        run_op(1'b0, 5'b11111, 5'b00001, 1'b1, 5, "hold5");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        bit p;
        logic [W+2:0] exp;
        do_reset();
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
            a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
            req0 = 1'b1; req1 = 1'b1;
            #1;
            p = ~model_last;
            exp = p ? model_add(a1, b1, cin1) : model_add(a0, b0, cin0);
            vectors++;
            if ({gnt1, gnt0} !== (p ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("[TB] FAIL rr grant %0d: got %b expected %b", k, {gnt1, gnt0}, (p ? 2'b10 : 2'b01));
            end
            model_last = p;
            tick();
            tick();
            vectors++;
            if ({res_valid, res_id, res_ovf, res_cout, res_sum} !== {1'b1, p, exp} || {gnt1, gnt0} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL rr result %0d: got %b gnt %b expected %b gnt 00", k,
                         {res_valid, res_id, res_ovf, res_cout, res_sum}, {gnt1, gnt0}, {1'b1, p, exp});
            end
            tick();
            exp_count = (exp_count + 1) % (1 << CNTW);
            vectors++;
            if (op_count !== CNTW'(exp_count)) begin
                miscompares++;
                $display("[TB] FAIL rr count %0d: got %0d expected %0d", k, op_count, exp_count);
            end
        end
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_fixed_priority();
        int fp_count;
        logic [W+2:0] exp;
        do_reset();
        fp_count  = 0;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
            a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
            req0 = 1'b1; req1 = 1'b1;
            #1;
            exp = model_add(a0, b0, cin0);
            vectors++;
            if ({fp_gnt1, fp_gnt0} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL fp grant %0d: got %b expected 01", k, {fp_gnt1, fp_gnt0});
            end
            tick();
            tick();
            vectors++;
            if ({fp_res_valid, fp_res_id, fp_res_ovf, fp_res_cout, fp_res_sum} !== {2'b10, exp} || fp_gnt1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL fp result %0d: got %b gnt1 %b expected %b gnt1 0", k,
                         {fp_res_valid, fp_res_id, fp_res_ovf, fp_res_cout, fp_res_sum}, fp_gnt1, {2'b10, exp});
            end
            tick();
            fp_count++;
            vectors++;
            if (fp_op_count !== CNTW'(fp_count)) begin
                miscompares++;
                $display("[TB] FAIL fp count %0d: got %0d expected %0d", k, fp_op_count, fp_count);
            end
        end
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_midop();
        do_reset();
        run_op(1'b0, W'($urandom), W'($urandom), 1'($urandom), 0, "pre_reset");
        // Reset while in CALC
        req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
        tick();
        req0  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; model_last = 1'b1; exp_count = 0;
        vectors++;
        if ({res_valid, busy, res_cout, res_ovf, res_id} !== 5'b0 || res_sum !== '0 || op_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset in calc: flags %b sum %b count %0d expected all zero",
                     {res_valid, busy, res_cout, res_ovf, res_id}, res_sum, op_count);
        end
        req0 = 1'b1; req1 = 1'b1;
        #1;
        vectors++;
        if ({gnt1, gnt0} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL post reset grant: got %b expected 01", {gnt1, gnt0});
        end
        // Reset while in HOLD
        tick();
        tick();
        req0  = 1'b0; req1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({res_valid, busy} !== 2'b00 || res_sum !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset in hold: valid/busy %b sum %b expected 00/0", {res_valid, busy}, res_sum);
        end
        do_reset();
    endtask

    task automatic test_count_wrap();
        do_reset();
        req0 = 1'b1; a0 = 5'b00011; b0 = 5'b00100; cin0 = 1'b0;
        res_ready = 1'b1;
        repeat (255 * 3) tick();
        vectors++;
        if (op_count !== 8'd255) begin
            miscompares++;
            $display("[TB] FAIL count at max: got %0d expected 255", op_count);
        end
        repeat (3) tick();
        vectors++;
        if (op_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL count wrap: got %0d expected 0", op_count);
        end
        req0 = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
        a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        model_last = 1'b1; exp_count = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_fixed_priority();
        test_reset_midop();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one W-bit signed ripple adder between two independent requesters (port 0, port 1).
- Arbitrates round-robin (or fixed-priority, by parameter) and registers the operands.
- Computes a sign-extended (W+1)-bit sum with carry-out and a W-bit overflow flag.
- Holds the tagged result until the consumer accepts it.
- Sits between the requesting control logic and the shared arithmetic datapath; it is the only driver of the adder's inputs.

Parameters:
- W, 5, operand width in bits; the result is W+1 bits.
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- CNTW, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req0  input  1  port 0 request; held with operands until gnt0.
- a0  input  W  port 0 operand A (two's complement).
- b0  input  W  port 0 operand B.
- cin0  input  1  port 0 carry-in.
- gnt0  output  1  port 0 grant; operands are captured at the clock edge where gnt0=1.
- req1, a1, b1, cin1  input  1/W/W/1  port 1 request and operands, same rules as port 0.
- gnt1  output  1  port 1 grant.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  W+1  sign-extended sum.
- res_cout  output  1  carry out of bit W.
- res_ovf  output  1  result does not fit in W bits (res_sum[W] != res_sum[W-1]).
- res_id  output  1  port that issued the operation.
- busy  output  1  state != IDLE.
- op_count  output  CNTW  completed (accepted) operations; wraps modulo 2^CNTW.

Behaviour:
- Reset: synchronous on rst_n=0 at a clock edge; dominates all other inputs and may occur in any state.
  - Clears state to IDLE, all result outputs, op_count, and operand registers.
  - Sets last_grant=1, so port 0 has priority first.
  - An in-flight operation is dropped.
- FSM states are IDLE, CALC and HOLD.
- IDLE:
  - gnt0/gnt1 are combinational; at most one is high, and only in IDLE.
  - Both requesting with FAIR=1: grant the port != last_grant.
  - Both requesting with FAIR=0: grant port 0.
  - Single requester: grant it.
  - At the edge with a grant: capture a, b, cin and id; update last_grant; go to CALC.
- CALC:
  - The adder sees the registered operands: sum = sext(a) + sext(b) + cin, computed at W+2 bits.
  - res_sum = bits[W:0]; res_cout = bit W+1 of the unsigned sum of the sign-extended (W+1)-bit operands.
  - At the edge: register the outputs, set res_valid=1, go to HOLD.
- HOLD:
  - res_* stay stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready at an edge: res_valid=0, op_count+1, go to IDLE.
  - No new grant is issued in the same cycle.
- Latency: grant at cycle N, res_valid high from cycle N+2; minimum 3 cycles per operation.
- Requests during CALC/HOLD are not granted; requesters keep req high. A requester may withdraw req before it is granted.
- res_ready during IDLE/CALC is ignored.
- op_count wraps from 2^CNTW-1 to 0.
- Arithmetic with W=5: the (W+1)-bit signed result cannot overflow; res_ovf reports only that the result falls outside the W-bit range.

Test Plan:
- Reset, then req0 only, a0=01111, b0=00001, cin0=0 -> gnt0 pulses at cycle 0; at cycle 2: res_valid=1, res_sum=010000, res_ovf=1, res_cout=0, res_id=0.
- req1 only, a1=10000, b1=10000, cin1=0 -> res_sum=100000 (-32), res_cout=1, res_ovf=1, res_id=1.
- req0 and req1 held high, res_ready=1, FAIR=1 -> grants alternate 0,1,0,1, one every 3 cycles; op_count increments at each accept.
- Same stimulus with FAIR=0 -> port 0 granted every time, port 1 starved; gnt1 never high.
- Result ready withheld 5 cycles, a0=11111, b0=00001, cin0=1 -> res_sum=000001 stable over the 5 cycles, res_ovf=0, busy=1; no grant until the accept.
- rst_n=0 in CALC or HOLD -> next cycle all outputs 0 and state IDLE; a subsequent req1+req0 grants port 0 first.
